norm32: RTL and testbench
=========================

Name: norm32

Overview:
- Iterative normaliser: the inverse of the left shifter. Takes a 32-bit operand and shifts it left until its MSB is significant, then returns the normalised value and the shift count that got there.
- Unsigned mode: counts leading zeros. Signed mode: counts redundant sign bits.
- Sits beside the shift unit in the ALU. Feeds divide, float-convert and CLZ/CLS instructions.
- Multicycle with valid/ready on both sides; one operation in flight.

Parameters:
- STEP, 8, coarse shift distance per cycle; legal 1..16; STEP=1 gives pure bit-serial operation.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block idle, operand accepted when in_valid is also high.
- in_a  input  32  operand.
- in_sgn  input  1  1 = signed (count redundant sign bits), 0 = unsigned (count leading zeros).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- out_res  output  32  normalised value, in_a << out_cnt.
- out_cnt  output  6  shift count: 0..32 unsigned, 0..31 signed.
- out_zero  output  1  operand was 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset (including mid-operation): state=IDLE, in_ready=1, out_valid=0, out_res=0, out_cnt=0, out_zero=0. Any in-flight operation is discarded with no output.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge E0, latch in_a into v, in_sgn into s, set cnt=0.
  - Special operands go straight to DONE:
    - Unsigned and in_a==0: res=0, cnt=32, zero=1.
    - Signed and in_a all zeros: res=0, cnt=31, zero=1.
    - Signed and in_a all ones: res=0x80000000, cnt=31, zero=0.
  - Any other operand goes to SCAN.
- SCAN: one evaluation per edge, checked in this priority order:
  - Done condition (unsigned: v[31]=1; signed: v[31]!=v[30]) → DONE; v and cnt unchanged.
  - Else coarse condition (unsigned: v[31:32-STEP] all 0; signed: v[31:31-STEP] all equal) → v <= v<<STEP, cnt += STEP.
  - Else → v <= v<<1, cnt += 1.
  - Coarse shift never overshoots; cnt never exceeds 31 in SCAN.
- DONE:
  - out_valid=1; out_res, out_cnt, out_zero are stable and held while out_ready=0.
  - On out_ready, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - in_ready=0 throughout SCAN and DONE; in_valid is ignored there.
- Latency: special operands give out_valid in the cycle after E0. Otherwise out_valid follows SCAN edge E(k), where k = coarse steps + fine steps + 1.
- Arithmetic:
  - Left shifts zero-fill.
  - cnt is 6-bit unsigned, no wrap possible.
  - out_res == in_a << out_cnt for all non-zero operands.
- Throughput: at most one result per (latency + 1) cycles. Back-to-back is legal: in_valid may be held high in the cycle in_ready rises.
- Simultaneous rst with any handshake: rst wins.

Test Plan:
- Unsigned 0x80000000: SCAN done at E1 → out_valid after E1, res=0x80000000, cnt=0, zero=0.
- Unsigned 0x00000001, STEP=8: 3 coarse + 7 fine + 1 detect = 11 SCAN edges → out_valid after E11, res=0x80000000, cnt=31.
- Unsigned 0x00010000, STEP=8: 9 SCAN edges → res=0x80000000, cnt=15.
- Zero operands:
  - Unsigned 0 → res=0, cnt=32, zero=1, out_valid after E0.
  - Signed 0 → res=0, cnt=31, zero=1.
  - Signed 0xFFFFFFFF → res=0x80000000, cnt=31, zero=0.
- Signed 0xFFFFFFF0 → res=0x80000000, cnt=27. Signed 0x00001234 → res=0x48D00000, cnt=18.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0.
  - Release out_ready: in_ready=1 next cycle; a second operand is accepted in that cycle.
  - Assert rst mid-SCAN: next cycle IDLE with all outputs 0, and no stale out_valid afterwards.

Source files
------------

// File: rtl/norm32.sv
`default_nettype none
// ============================================================================
// norm32 : iterative left normaliser (CLZ / CLS) with valid/ready handshake
// Revision: 1.0
// ============================================================================
module norm32 #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic        in_sgn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [5:0]  out_cnt,
  output logic        out_zero
);

  localparam logic [5:0] C_STEP = 6'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] v_q;
  logic [5:0]  cnt_q;
  logic        sgn_q;
  logic        zero_q;

  logic [STEP:0] w_top;
  logic          w_done;
  logic          w_coarse;
  logic [31:0]   v_d;
  logic [5:0]    cnt_d;

  // Signed mode looks at STEP+1 bits: STEP redundant copies of the sign bit.
  always_comb begin
    w_top    = v_q[31 -: STEP + 1];
    w_done   = sgn_q ? (v_q[31] ^ v_q[30]) : v_q[31];
    w_coarse = sgn_q ? ((&w_top) | ~(|w_top)) : ~(|w_top[STEP:1]);
    v_d      = v_q << 1;
    cnt_d    = cnt_q + 6'd1;
    if (w_coarse) begin
      v_d   = v_q << STEP;
      cnt_d = cnt_q + C_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      v_q         <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sgn_q      <= in_sgn;
            in_ready_q <= 1'b0;
            // Operands with no significant bit to find finish without scanning.
            if (in_a == 32'h0000_0000) begin
              v_q         <= '0;
              cnt_q       <= in_sgn ? 6'd31 : 6'd32;
              zero_q      <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (in_sgn && (&in_a)) begin
              v_q         <= 32'h8000_0000;
              cnt_q       <= 6'd31;
              zero_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              v_q     <= in_a;
              cnt_q   <= '0;
              zero_q  <= 1'b0;
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_done) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = v_q;
  assign out_cnt   = cnt_q;
  assign out_zero  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_norm32.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for norm32: directed corner operands, random operands,
// output hold/back-to-back handshake and reset in the middle of a scan.
module tb_norm32;
  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_sgn, out_valid, out_ready, out_zero;
  logic [31:0] in_a, out_res;
  logic [5:0]  out_cnt;
  int          tests = 0;
  int          fails = 0;

  norm32 #(.STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_sgn(in_sgn), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cnt(out_cnt), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Reference: count leading zeros / redundant sign bits directly, then
  // derive latency from how many full STEP moves and single moves it takes.
  function automatic void model(input logic [31:0] a, input logic s,
                                output logic [31:0] res, output logic [5:0] cnt,
                                output logic z, output int lat);
    int n;
    n = 0;
    if (a == 32'h0) begin
      res = 32'h0; cnt = s ? 6'd31 : 6'd32; z = 1'b1; lat = 0;
    end else if (s && a == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000; cnt = 6'd31; z = 1'b0; lat = 0;
    end else begin
      if (!s) begin
        while (a[31 - n] == 1'b0) n++;
      end else begin
        while (a[30 - n] == a[31]) n++;
      end
      res = a << n; cnt = 6'(n); z = 1'b0;
      lat = n / STEP + n % STEP + 1;
    end
  endfunction

  // Drives one operand from a negedge; returns the captured result and the
  // number of edges after acceptance until out_valid (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic s,
                        output logic [31:0] res, output logic [5:0] cnt,
                        output logic z, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); @(negedge clk); w++;
    end
    in_valid = 1'b1; in_a = a; in_sgn = s;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    if (!out_valid) lat = -1;
    res = out_res; cnt = out_cnt; z = out_zero;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_res !== 32'h0) begin fails++; $display("FAIL reset_out_res got %h exp 0", out_res); end
    tests++; if (out_cnt !== 6'd0) begin fails++; $display("FAIL reset_out_cnt got %0d exp 0", out_cnt); end
    tests++; if (out_zero !== 1'b0) begin fails++; $display("FAIL reset_out_zero got %b exp 0", out_zero); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] da [8] = '{32'h8000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0,
                            32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0000_1234};
    logic        ds [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] er [8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0,
                            32'h0, 32'h8000_0000, 32'h8000_0000, 32'h48D0_0000};
    int          ec [8] = '{0, 31, 15, 32, 31, 31, 27, 18};
    logic        ez [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          el [8] = '{1, 11, 9, 0, 0, 0, 7, 5};
    logic [31:0] r;
    logic [5:0]  c;
    logic        z;
    int          l;
    for (int i = 0; i < 8; i++) begin
      run_op(da[i], ds[i], r, c, z, l);
      tests++; if (r !== er[i]) begin fails++; $display("FAIL dir_res[%0d] got %h exp %h", i, r, er[i]); end
      tests++; if (c !== 6'(ec[i])) begin fails++; $display("FAIL dir_cnt[%0d] got %0d exp %0d", i, c, ec[i]); end
      tests++; if (z !== ez[i]) begin fails++; $display("FAIL dir_zero[%0d] got %b exp %b", i, z, ez[i]); end
      tests++; if (l != el[i]) begin fails++; $display("FAIL dir_lat[%0d] got %0d exp %0d", i, l, el[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, r, mr;
    logic [5:0]  c, mc;
    logic        s, z, mz;
    int          l, ml, sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 15);
      a = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) a = ~a;
      if (sel == 0) a = 32'h0;
      if (sel == 1) a = 32'hFFFF_FFFF;
      model(a, s, mr, mc, mz, ml);
      run_op(a, s, r, c, z, l);
      tests++; if (r !== mr) begin fails++; $display("FAIL rnd_res a=%h s=%b got %h exp %h", a, s, r, mr); end
      tests++; if (c !== mc) begin fails++; $display("FAIL rnd_cnt a=%h s=%b got %0d exp %0d", a, s, c, mc); end
      tests++; if (z !== mz) begin fails++; $display("FAIL rnd_zero a=%h s=%b got %b exp %b", a, s, z, mz); end
      tests++; if (l != ml) begin fails++; $display("FAIL rnd_lat a=%h s=%b got %0d exp %0d", a, s, l, ml); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mr, r;
    logic [5:0]  mc, c;
    logic        mz, z;
    int          ml, l;
    model(32'h0000_0F00, 1'b0, mr, mc, mz, ml);
    in_valid = 1'b1; in_a = 32'h0000_0F00; in_sgn = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 200) begin @(posedge clk); @(negedge clk); l++; end
    tests++; if (l != ml) begin fails++; $display("FAIL hold_lat got %0d exp %0d", l, ml); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_res !== mr || out_cnt !== mc || in_ready !== 1'b0)
        begin fails++; $display("FAIL hold[%0d] got v=%b res=%h cnt=%0d rdy=%b exp v=1 res=%h cnt=%0d rdy=0",
                                i, out_valid, out_res, out_cnt, in_ready, mr, mc); end
    end
    // Release the result while already presenting the next operand.
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'h0000_0003; in_sgn = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin fails++; $display("FAIL release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_accept got rdy=%b exp 0", in_ready); end
    model(32'h0000_0003, 1'b1, mr, mc, mz, ml);
    l = 0;
    while (!out_valid && l < 200) begin @(posedge clk); @(negedge clk); l++; end
    r = out_res; c = out_cnt; z = out_zero;
    tests++; if (r !== mr || c !== mc || z !== mz || l != ml)
      begin fails++; $display("FAIL b2b_result got %h/%0d/%b/%0d exp %h/%0d/%b/%0d", r, c, z, l, mr, mc, mz, ml); end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic        seen;
    logic [31:0] mr, r;
    logic [5:0]  mc, c;
    logic        mz, z;
    int          ml, l;
    in_valid = 1'b1; in_a = 32'h0000_0001; in_sgn = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 32'h0 || out_cnt !== 6'd0 || out_zero !== 1'b0)
      begin fails++; $display("FAIL midrst got rdy=%b v=%b res=%h cnt=%0d z=%b exp 1/0/0/0/0",
                              in_ready, out_valid, out_res, out_cnt, out_zero); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_stale got %b exp 0", seen); end
    model(32'h0400_0000, 1'b0, mr, mc, mz, ml);
    run_op(32'h0400_0000, 1'b0, r, c, z, l);
    tests++; if (r !== mr || c !== mc || l != ml)
      begin fails++; $display("FAIL midrst_after got %h/%0d/%0d exp %h/%0d/%0d", r, c, l, mr, mc, ml); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_sgn = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
